// File: rtl/tv80_tb_pkg.sv
// tv80_tb_pkg: shared types and defaults for the tv80 bus memory model
package tv80_tb_pkg;
    localparam logic [7:0] DEF_IO_PAGE = 8'h10;
    typedef struct packed {
        logic        io;
        logic [15:0] addr;
        logic [7:0]  data;
    } trace_entry_t;
    typedef enum logic [1:0] {IDLE, COUNT, DONE} wait_state_e;
endpackage

// File: rtl/tv80_trace_fifo.sv
// tv80_trace_fifo: write-trace FIFO with sticky overflow flag
module tv80_trace_fifo
    import tv80_tb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty,
    output logic   ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    entry_t        store [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_pop, do_push;
    assign empty   = cnt == '0;
    assign full    = cnt == CW'(DEPTH);
    assign do_pop  = pop & !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push & (!full | do_pop);
    assign dout    = store[rp];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            wp  <= wp + PW'(do_push);
            rp  <= rp + PW'(do_pop);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
            if (push && !do_push) ovf <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) store[wp] <= din;
    end
endmodule

// File: rtl/tv80_bus_mem_model.sv
// tv80_bus_mem_model: tv80s memory/IO responder with wait states, backdoor loader and write trace
module tv80_bus_mem_model
    import tv80_tb_pkg::*;
#(
    parameter int         AW          = 16,
    parameter logic [7:0] IO_PAGE     = DEF_IO_PAGE,
    parameter int         WAIT_MEM    = 0,
    parameter int         WAIT_IO     = 0,
    parameter int         TRACE_DEPTH = 16,
    parameter logic [7:0] RD_RESET    = 8'hFF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   cpu_a,
    input  logic [7:0]    cpu_do,
    output logic [7:0]    cpu_di,
    input  logic          mreq_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    input  logic          m1_n,
    output logic          wait_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          trc_valid,
    input  logic          trc_ready,
    output logic          trc_io,
    output logic [15:0]   trc_addr,
    output logic [7:0]    trc_data,
    output logic          trc_ovf
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] mem_addr, io_addr, ld_addr_q;
    logic [7:0]    mem_o, io_o, ld_data_q;
    logic          ld_q, mem_act, io_act, act, act_q, start, push, empty, wait_d;
    logic [3:0]    cnt, cnt_d, load;
    wait_state_e   state, state_d;
    trace_entry_t  head;
    assign mem_addr = cpu_a[AW-1:0];
    assign io_addr  = AW'({IO_PAGE, cpu_a[7:0]});
    assign cpu_di   = !iorq_n ? io_o : mem_o;
    // backdoor capture is unreset: loading happens while reset is held
    always_ff @(posedge clk) begin
        ld_q      <= ld_en;
        ld_addr_q <= ld_addr;
        ld_data_q <= ld_data;
    end
    // single writer for the store; backdoor lands half a cycle after its sampling edge
    always_ff @(negedge clk) begin
        if (ld_q) mem[ld_addr_q] <= ld_data_q;
        if (!wr_n && !mreq_n) mem[mem_addr] <= cpu_do;
        else if (!wr_n && !iorq_n) mem[io_addr] <= cpu_do;
    end
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_o <= RD_RESET;
            io_o  <= RD_RESET;
        end else begin
            mem_o <= mem[mem_addr];
            io_o  <= mem[io_addr];
        end
    end
    assign mem_act = !mreq_n & (!rd_n | !wr_n);
    assign io_act  = !iorq_n & m1_n & (!rd_n | !wr_n);
    assign act     = mem_act | io_act;
    assign start   = act & !act_q;
    assign load    = mem_act ? 4'(WAIT_MEM) : 4'(WAIT_IO);
    assign push    = start & !wr_n;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wait_d  = 1'b1;
        unique case (state)
            IDLE: if (start) begin
                cnt_d   = load;
                state_d = load == '0 ? DONE : COUNT;
                wait_d  = load == '0;
            end
            COUNT: if (!act) state_d = IDLE;
            else begin
                cnt_d   = cnt - 4'd1;
                state_d = cnt == 4'd1 ? DONE : COUNT;
                wait_d  = cnt == 4'd1;
            end
            DONE: if (!act) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            wait_n <= 1'b1;
            act_q  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            wait_n <= wait_d;
            act_q  <= act;
        end
    end
    tv80_trace_fifo #(.DEPTH(TRACE_DEPTH), .entry_t(trace_entry_t)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     ('{io: !mem_act, addr: cpu_a, data: cpu_do}),
        .pop     (trc_ready),
        .dout    (head),
        .full    (),
        .empty   (empty),
        .ovf     (trc_ovf)
    );
    assign trc_valid = !empty;
    assign trc_io    = head.io;
    assign trc_addr  = head.addr;
    assign trc_data  = head.data;
endmodule

// File: tb/tb_tv80_bus_mem_model.sv
// tb_tv80_bus_mem_model: directed bus-cycle checks of the tv80 memory/IO responder
module tb_tv80_bus_mem_model;
    logic        clk, reset_n, mreq_n, iorq_n, rd_n, wr_n, m1_n, ld_en, trc_ready;
    logic [15:0] cpu_a, ld_addr;
    logic [7:0]  cpu_do, ld_data;
    logic [7:0]  cpu_di, cpu_di0, trc_data, trc_data0;
    logic        wait_n, wait_n0, trc_valid, trc_valid0, trc_io, trc_io0, trc_ovf, trc_ovf0;
    logic [15:0] trc_addr, trc_addr0;
    int vecs = 0, errs = 0, dut_low = 0, w0_low = 0;

    tv80_bus_mem_model #(.WAIT_MEM(2), .WAIT_IO(1), .TRACE_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_io(trc_io),
        .trc_addr(trc_addr), .trc_data(trc_data), .trc_ovf(trc_ovf));

    tv80_bus_mem_model dut0 (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di0),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .wait_n(wait_n0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .trc_valid(trc_valid0), .trc_ready(trc_ready), .trc_io(trc_io0),
        .trc_addr(trc_addr0), .trc_data(trc_data0), .trc_ovf(trc_ovf0));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!wait_n) dut_low++;
        if (!wait_n0) w0_low++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic io, input logic wr, input logic [15:0] addr, input logic [7:0] d,
                         output logic [7:0] q, output logic [7:0] q0, output int waits);
        cpu_a = addr;
        cpu_do = d;
        m1_n = 1'b1;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        tick();
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        tick();
        waits = 0;
        while (!wait_n && waits < 20) begin
            waits++;
            tick();
        end
        tick();
        q = cpu_di;
        q0 = cpu_di0;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        tick();
    endtask

    task automatic load(input logic [15:0] addr, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = addr; ld_data = d;
        tick();
        ld_en = 1'b0;
        tick();
    endtask

    task automatic pop1();
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] q, q0;
        int w, base;
        reset_n = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; trc_ready = 1'b0; cpu_a = '0; cpu_do = '0;
        tick(); tick();
        chk("rst_cpu_di", cpu_di, 8'hFF);
        chk("rst_wait_n", wait_n, 1'b1);
        chk("rst_trc_valid", trc_valid, 1'b0);
        chk("rst_trc_ovf", trc_ovf, 1'b0);
        load(16'h0AC5, 8'hE0);
        load(16'h5555, 8'hA5);
        reset_n = 1'b1;
        tick();
        cycle(1'b0, 1'b0, 16'h0AC5, 8'h00, q, q0, w);
        chk("bd_read", q, 8'hE0);
        chk("bd_read_w0", q0, 8'hE0);
        chk("rd_waits", w, 2);
        cycle(1'b0, 1'b0, 16'h5555, 8'h00, q, q0, w);
        chk("bd_read2", q, 8'hA5);
        cycle(1'b0, 1'b1, 16'h0AC5, 8'hE4, q, q0, w);
        chk("wr_waits", w, 2);
        chk("wr_trc_valid", trc_valid, 1'b1);
        chk("wr_head", {7'd0, trc_io, trc_addr, trc_data}, {7'd0, 1'b0, 16'h0AC5, 8'hE4});
        cycle(1'b0, 1'b0, 16'h0AC5, 8'h00, q, q0, w);
        chk("rdback", q, 8'hE4);
        chk("rdback_w0", q0, 8'hE4);
        cycle(1'b1, 1'b1, 16'h1234, 8'h5A, q, q0, w);
        chk("io_waits", w, 1);
        cycle(1'b0, 1'b0, 16'h1034, 8'h00, q, q0, w);
        chk("io_window_mem", q, 8'h5A);
        cycle(1'b1, 1'b0, 16'h5634, 8'h00, q, q0, w);
        chk("io_read", q, 8'h5A);
        chk("io_read_waits", w, 1);
        pop1();
        chk("io_head", {7'd0, trc_io, trc_addr, trc_data}, {7'd0, 1'b1, 16'h1234, 8'h5A});
        pop1();
        chk("drained", trc_valid, 1'b0);
        base = dut_low;
        mreq_n = 1'b0;
        tick(); tick(); tick();
        mreq_n = 1'b1; iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
        tick(); tick(); tick();
        iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1;
        tick();
        chk("refresh_ack_no_wait", dut_low - base, 0);
        chk("refresh_ack_no_trace", trc_valid, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 16'h2000 + 16'(i), 8'h11 + 8'(i), q, q0, w);
        chk("full_no_ovf", trc_ovf, 1'b0);
        cycle(1'b0, 1'b1, 16'h2004, 8'h15, q, q0, w);
        chk("ovf_set", trc_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d", i), {7'd0, trc_io, trc_addr, trc_data},
                {7'd0, 1'b0, 16'h2000 + 16'(i), 8'h11 + 8'(i)});
            pop1();
        end
        chk("empty_after_pops", trc_valid, 1'b0);
        chk("ovf_sticky", trc_ovf, 1'b1);
        pop1();
        cycle(1'b0, 1'b1, 16'h3000, 8'h77, q, q0, w);
        chk("head_after_empty_pop", {7'd0, trc_io, trc_addr, trc_data}, {7'd0, 1'b0, 16'h3000, 8'h77});
        cpu_a = 16'h2001; mreq_n = 1'b0; rd_n = 1'b0;
        tick();
        chk("mid_wait_low", wait_n, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("async_wait_rel", wait_n, 1'b1);
        chk("rst_valid_clr", trc_valid, 1'b0);
        chk("rst_ovf_clr", trc_ovf, 1'b0);
        mreq_n = 1'b1; rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        cycle(1'b0, 1'b0, 16'h2001, 8'h00, q, q0, w);
        chk("kept_2001", q, 8'h12);
        cycle(1'b0, 1'b0, 16'h3000, 8'h00, q, q0, w);
        chk("kept_3000", q, 8'h77);
        chk("zero_wait_never_low", w0_low, 0);
        chk("w0_ovf", trc_ovf0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
